// File: rtl/d_mem_if.sv
// Request/acknowledge bundle between the bfcpu data port and the tape memory.
interface d_mem_if #(
  parameter int unsigned addr_width = 8,
  parameter int unsigned data_width = 8
);
  logic                  d_req;
  logic                  d_dir;
  logic [addr_width-1:0] d_addr;
  logic [data_width-1:0] d_wdata;
  logic                  d_clear;
  logic                  d_ack;
  logic [data_width-1:0] d_rdata;
  logic                  d_busy;

  modport master (
    output d_req, d_dir, d_addr, d_wdata, d_clear,
    input  d_ack, d_rdata, d_busy
  );

  modport slave (
    input  d_req, d_dir, d_addr, d_wdata, d_clear,
    output d_ack, d_rdata, d_busy
  );
endinterface

// File: rtl/d_mem_ctrl.sv
// Data-tape memory for the bfcpu core: handshaked single-port RAM with
// configurable wait states and a zero-fill sweep after reset or on command.
module d_mem_ctrl #(
  parameter int unsigned d_addr_width   = 8,
  parameter int unsigned d_data_width   = 8,
  parameter int unsigned d_mem_length   = 64,
  parameter logic [3:0]  wait_states    = 4'd0,
  parameter bit          clear_on_reset = 1'b1
) (
  input  logic   clk,
  input  logic   rst_n,
  d_mem_if.slave bus
);
  localparam int unsigned    PTR_W     = (d_mem_length > 1) ? $clog2(d_mem_length) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(d_mem_length - 1);
  localparam logic           DIR_WRITE = 1'b1;

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_ACCESS, S_ACK} state_t;

  state_t                  r_state;
  logic [3:0]              r_cnt;
  logic [PTR_W-1:0]        r_ptr;
  logic [d_addr_width-1:0] r_addr;
  logic                    r_dir;
  logic [d_data_width-1:0] r_wdata;
  logic [d_data_width-1:0] r_rdata;
  logic                    r_ack;
  logic                    r_busy;
  logic [d_data_width-1:0] r_mem [d_mem_length];

  logic                    w_in_range;
  logic [PTR_W-1:0]        w_idx;
  logic                    w_op;
  logic                    w_mem_we;
  logic [PTR_W-1:0]        w_mem_idx;
  logic [d_data_width-1:0] w_mem_wdata;

  assign w_in_range  = (32'(r_addr) < d_mem_length);
  assign w_idx       = r_addr[PTR_W-1:0];
  assign w_op        = (r_state == S_ACCESS) && (r_cnt == 4'd0);
  // The sweep and the access path share the single RAM write port.
  assign w_mem_we    = (r_state == S_CLEAR) || (w_op && (r_dir == DIR_WRITE) && w_in_range);
  assign w_mem_idx   = (r_state == S_CLEAR) ? r_ptr : w_idx;
  assign w_mem_wdata = (r_state == S_CLEAR) ? '0 : r_wdata;

  // RAM array: deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_idx] <= w_mem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= clear_on_reset ? S_CLEAR : S_IDLE;
      r_busy  <= clear_on_reset;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_addr  <= '0;
      r_dir   <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        S_CLEAR: begin
          if (r_ptr == PTR_LAST) begin
            r_ptr   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_ptr <= r_ptr + PTR_W'(1);
          end
        end
        S_IDLE: begin
          if (bus.d_clear) begin
            r_busy  <= 1'b1;
            r_state <= S_CLEAR;
          end else if (bus.d_req) begin
            r_addr  <= bus.d_addr;
            r_dir   <= bus.d_dir;
            r_wdata <= bus.d_wdata;
            r_cnt   <= wait_states;
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            if (r_dir != DIR_WRITE) r_rdata <= w_in_range ? r_mem[w_idx] : '0;
            r_ack   <= 1'b1;
            r_state <= S_ACK;
          end
        end
        S_ACK:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.d_ack   = r_ack;
  assign bus.d_rdata = r_rdata;
  assign bus.d_busy  = r_busy;
endmodule

// File: tb/tb_d_mem_ctrl.sv
// Scoreboard bench for d_mem_ctrl: one instance with no wait states, one with three.
module tb_d_mem_ctrl;
  localparam logic DIR_W = 1'b1;
  localparam logic DIR_R = 1'b0;

  typedef struct {
    int         sel;
    logic [7:0] exp;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]      t_req, t_dir, t_clear;
  logic [1:0][7:0] t_addr, t_wdata;
  logic [1:0]      ack, busy;
  logic [1:0][7:0] rdata;

  d_mem_if #(.addr_width(8), .data_width(8)) bus0 ();
  d_mem_if #(.addr_width(8), .data_width(8)) bus3 ();

  assign bus0.d_req   = t_req[0];
  assign bus0.d_dir   = t_dir[0];
  assign bus0.d_addr  = t_addr[0];
  assign bus0.d_wdata = t_wdata[0];
  assign bus0.d_clear = t_clear[0];
  assign bus3.d_req   = t_req[1];
  assign bus3.d_dir   = t_dir[1];
  assign bus3.d_addr  = t_addr[1];
  assign bus3.d_wdata = t_wdata[1];
  assign bus3.d_clear = t_clear[1];
  assign ack[0]   = bus0.d_ack;
  assign ack[1]   = bus3.d_ack;
  assign busy[0]  = bus0.d_busy;
  assign busy[1]  = bus3.d_busy;
  assign rdata[0] = bus0.d_rdata;
  assign rdata[1] = bus3.d_rdata;

  d_mem_ctrl #(.d_addr_width(8), .d_data_width(8), .d_mem_length(64),
               .wait_states(4'd0), .clear_on_reset(1'b1))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  d_mem_ctrl #(.d_addr_width(8), .d_data_width(8), .d_mem_length(64),
               .wait_states(4'd3), .clear_on_reset(1'b1))
    u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  int         total = 0;
  int         bad   = 0;
  logic [7:0] mdl [2][64];
  logic [7:0] last_rd [2];
  sb_t        sb_q[$];

  function automatic int ws_of(input int sel);
    return (sel == 0) ? 0 : 3;
  endfunction

  task automatic model_clear(input int sel);
    for (int k = 0; k < 64; k++) mdl[sel][k] = 8'h00;
    last_rd[sel] = 8'h00;
  endtask

  // Push the expected completion, run one handshake, pop and compare on d_ack.
  task automatic xact(input int sel, input logic dir, input logic [7:0] addr,
                      input logic [7:0] wdata, input bit mod_wd);
    sb_t e;
    int  edges;
    bit  got;
    e.sel = sel;
    if (dir == DIR_W) begin
      if (addr < 8'd64) mdl[sel][addr[5:0]] = wdata;
      e.exp = last_rd[sel];
    end else begin
      e.exp = (addr < 8'd64) ? mdl[sel][addr[5:0]] : 8'h00;
      last_rd[sel] = e.exp;
    end
    sb_q.push_back(e);
    @(negedge clk);
    t_req[sel] = 1'b1; t_dir[sel] = dir; t_addr[sel] = addr; t_wdata[sel] = wdata;
    edges = 0; got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk); #1;
      edges++;
      if (edges == 1 && mod_wd) t_wdata[sel] = ~wdata;
      if (ack[sel]) got = 1'b1;
    end
    t_req[sel] = 1'b0;
    e = sb_q.pop_front();
    total++;
    if (!got) begin
      bad++;
      $display("FAIL ack_timeout sel=%0d addr=%h got=no_ack want=ack", sel, addr);
    end else begin
      total++;
      if (edges !== 2 + ws_of(e.sel)) begin
        bad++;
        $display("FAIL latency sel=%0d addr=%h got=%0d want=%0d", sel, addr, edges, 2 + ws_of(e.sel));
      end
      if (rdata[sel] !== e.exp) begin
        bad++;
        $display("FAIL rdata sel=%0d dir=%0b addr=%h got=%h want=%h", sel, dir, addr, rdata[sel], e.exp);
      end
      @(posedge clk); #1;
      total++;
      if (ack[sel] !== 1'b0) begin
        bad++;
        $display("FAIL ack_pulse sel=%0d got=%b want=0", sel, ack[sel]);
      end
    end
  endtask

  task automatic wait_sweep(input string tag, output bit stale);
    int n;
    n = 0; stale = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      n++;
      if (ack != 2'b00) stale = 1'b1;
      if (!busy[0]) break;
    end
    total++;
    if (n !== 64 || busy !== 2'b00) begin
      bad++;
      $display("FAIL %s_sweep_len got=%0d busy=%b want=64 busy=00", tag, n, busy);
    end
  endtask

  task automatic test_reset();
    bit stale;
    t_req = '0; t_dir = '0; t_clear = '0; t_addr = '0; t_wdata = '0;
    rst_n = 1'b0;
    model_clear(0); model_clear(1);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (ack !== 2'b00 || rdata[0] !== 8'h00 || rdata[1] !== 8'h00 || busy !== 2'b11) begin
      bad++;
      $display("FAIL reset_state got ack=%b rd0=%h rd1=%h busy=%b want ack=00 rd=00 busy=11",
               ack, rdata[0], rdata[1], busy);
    end
    @(negedge clk) rst_n = 1'b1;
    wait_sweep("reset", stale);
    for (int a = 0; a < 64; a++) xact(0, DIR_R, 8'(a), 8'h00, 1'b0);
    xact(1, DIR_R, 8'h3F, 8'h00, 1'b0);
  endtask

  task automatic test_basic();
    xact(0, DIR_W, 8'h10, 8'hA5, 1'b0);
    xact(0, DIR_R, 8'h10, 8'h00, 1'b0);
  endtask

  task automatic test_wait_states();
    xact(1, DIR_W, 8'h20, 8'h5A, 1'b1);
    xact(1, DIR_R, 8'h20, 8'h00, 1'b0);
  endtask

  task automatic test_out_of_range();
    xact(0, DIR_W, 8'h50, 8'h33, 1'b0);
    xact(0, DIR_R, 8'h50, 8'h00, 1'b0);
    xact(0, DIR_R, 8'h10, 8'h00, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++)
      xact(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 79)), 8'($urandom), 1'b0);
  endtask

  task automatic test_clear_priority();
    sb_t e;
    int  edges, nb;
    bit  got, early;
    xact(0, DIR_W, 8'h05, 8'hFF, 1'b0);
    model_clear(0);
    e.sel = 0; e.exp = 8'h00;
    sb_q.push_back(e);
    @(negedge clk);
    t_clear[0] = 1'b1; t_req[0] = 1'b1; t_dir[0] = DIR_R; t_addr[0] = 8'h05;
    edges = 0; nb = 0; got = 1'b0; early = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(posedge clk); #1;
      t_clear[0] = 1'b0;
      edges++;
      if (busy[0]) nb++;
      if (ack[0]) begin
        got = 1'b1;
        if (busy[0]) early = 1'b1;
      end
    end
    t_req[0] = 1'b0;
    e = sb_q.pop_front();
    total++;
    if (!got || early || nb !== 64 || edges !== 67) begin
      bad++;
      $display("FAIL clear_prio got ack=%b early=%b busy_cycles=%0d ack_edge=%0d want 1 0 64 67",
               got, early, nb, edges);
    end
    total++;
    if (rdata[0] !== e.exp) begin
      bad++;
      $display("FAIL clear_prio_rdata got=%h want=%h", rdata[0], e.exp);
    end
    @(posedge clk); #1;
    xact(0, DIR_R, 8'h05, 8'h00, 1'b0);
  endtask

  task automatic test_reset_mid_access();
    bit stale;
    xact(1, DIR_R, 8'h20, 8'h00, 1'b0);
    @(negedge clk);
    t_req[1] = 1'b1; t_dir[1] = DIR_R; t_addr[1] = 8'h20;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (ack !== 2'b00 || rdata[1] !== 8'h00 || rdata[0] !== 8'h00 || busy !== 2'b11) begin
      bad++;
      $display("FAIL mid_reset got ack=%b rd0=%h rd1=%h busy=%b want ack=00 rd=00 busy=11",
               ack, rdata[0], rdata[1], busy);
    end
    t_req[1] = 1'b0;
    model_clear(0); model_clear(1);
    @(negedge clk) rst_n = 1'b1;
    wait_sweep("mid_reset", stale);
    repeat (4) begin
      @(posedge clk); #1;
      if (ack != 2'b00) stale = 1'b1;
    end
    total++;
    if (stale) begin
      bad++;
      $display("FAIL stale_ack got=ack_seen want=none");
    end
    xact(1, DIR_R, 8'h20, 8'h00, 1'b0);
    xact(0, DIR_R, 8'h10, 8'h00, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_states();
    test_out_of_range();
    test_back_to_back();
    test_clear_priority();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
